uart_wb_master: RTL and testbench

UART-to-Wishbone bridge master for FPGA emulation builds. A host PC sends framed commands over a board GPIO pin (8N1 UART). The block turns each command into a single 32-bit Wishbone classic cycle on the emulator's Wishbone slave port, standing in for the management SoC. It then returns the result to the host over a second GPIO pin.

---
 rtl/uart_wb_master.sv | 200 ++++++++++++++++++++
 tb/tb_uart_wb_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master.sv
// UART (8N1) to Wishbone classic bridge master: host commands become single 32-bit
// bus cycles, and the result is returned to the host as one or four bytes.
module uart_wb_master #(
    parameter int CLK_HZ  = 48000000,
    parameter int BAUD    = 115200,
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {C_IDLE, C_ADDR, C_DATA, C_BUS, C_RESP} cmd_state_t;

    rx_state_t      rx_state_q;
    logic           rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]  rx_cnt_q;
    logic [2:0]     rx_bit_q;
    logic [7:0]     rx_shift_q;
    logic           rx_valid_q, rx_ferr_q;

    cmd_state_t     cmd_state_q;
    logic [1:0]     byte_cnt_q;
    logic           cmd_we_q;
    logic [TW-1:0]  tmo_q;
    logic [31:0]    resp_q;
    logic [2:0]     resp_left_q;
    logic [3:0]     tx_bit_q;
    logic [CW-1:0]  tx_cnt_q;
    logic           tx_q, busy_q, cyc_q, we_q;
    logic [31:0]    adr_q, dat_q;
    logic [7:0]     tx_byte;

    assign tx_byte   = resp_q[31:24];
    assign uart_tx_o = tx_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = {4{cyc_q}};
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign busy_o    = busy_q;

    // Receiver: rx_valid_q / rx_ferr_q pulse on the edge that samples the stop bit.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
                    rx_state_q <= RX_START;
                    rx_cnt_q   <= '0;
                end
                RX_START: if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_q <= rx_cnt_q + CW'(1);
                end
                RX_DATA: if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                end else begin
                    rx_cnt_q <= rx_cnt_q + CW'(1);
                end
                RX_STOP: if (rx_cnt_q == DIV_LAST) begin
                    rx_valid_q <= rx_sync_q;
                    rx_ferr_q  <= !rx_sync_q;
                    rx_state_q <= RX_IDLE;
                end else begin
                    rx_cnt_q <= rx_cnt_q + CW'(1);
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Command sequencer, bus master and response transmitter share one FSM.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cmd_state_q <= C_IDLE;
            byte_cnt_q  <= '0;
            cmd_we_q    <= 1'b0;
            tmo_q       <= '0;
            resp_q      <= '0;
            resp_left_q <= '0;
            tx_bit_q    <= '0;
            tx_cnt_q    <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            case (cmd_state_q)
                C_IDLE: if (rx_valid_q) begin
                    busy_q     <= 1'b1;
                    byte_cnt_q <= '0;
                    cmd_we_q   <= (rx_shift_q == 8'h57);
                    if (rx_shift_q == 8'h57 || rx_shift_q == 8'h52) begin
                        cmd_state_q <= C_ADDR;
                    end else begin
                        resp_q      <= {8'h15, 24'h0};
                        resp_left_q <= 3'd1;
                        tx_q        <= 1'b0;
                        tx_bit_q    <= '0;
                        tx_cnt_q    <= '0;
                        cmd_state_q <= C_RESP;
                    end
                end
                C_ADDR, C_DATA: if (rx_ferr_q) begin
                    busy_q      <= 1'b0;
                    cmd_state_q <= C_IDLE;
                end else if (rx_valid_q) begin
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (cmd_state_q == C_ADDR) adr_q <= {adr_q[23:0], rx_shift_q};
                    else                       dat_q <= {dat_q[23:0], rx_shift_q};
                    if (byte_cnt_q == 2'd3) begin
                        if (cmd_state_q == C_ADDR && cmd_we_q) begin
                            cmd_state_q <= C_DATA;
                        end else begin
                            cyc_q       <= 1'b1;
                            we_q        <= cmd_we_q;
                            tmo_q       <= '0;
                            cmd_state_q <= C_BUS;
                        end
                    end
                end
                C_BUS: if (wbm_ack_i || tmo_q == TMO_LAST) begin
                    // Ack is tested first so an ack on the expiry edge still succeeds.
                    cyc_q       <= 1'b0;
                    we_q        <= 1'b0;
                    resp_q      <= !wbm_ack_i ? {8'h15, 24'h0} :
                                   cmd_we_q   ? {8'h06, 24'h0} : wbm_dat_i;
                    resp_left_q <= (wbm_ack_i && !cmd_we_q) ? 3'd4 : 3'd1;
                    tx_q        <= 1'b0;
                    tx_bit_q    <= '0;
                    tx_cnt_q    <= '0;
                    cmd_state_q <= C_RESP;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
                C_RESP: if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_q <= '0;
                    if (tx_bit_q == 4'd9) begin
                        if (resp_left_q == 3'd1) begin
                            busy_q      <= 1'b0;
                            cmd_state_q <= C_IDLE;
                        end else begin
                            resp_left_q <= resp_left_q - 3'd1;
                            resp_q      <= {resp_q[23:0], 8'h00};
                            tx_bit_q    <= '0;
                            tx_q        <= 1'b0;
                        end
                    end else begin
                        tx_bit_q <= tx_bit_q + 4'd1;
                        tx_q     <= (tx_bit_q == 4'd8) ? 1'b1 : tx_byte[tx_bit_q[2:0]];
                    end
                end else begin
                    tx_cnt_q <= tx_cnt_q + CW'(1);
                end
                default: cmd_state_q <= C_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: a host UART model, a programmable-latency Wishbone slave,
// and an expected-transaction queue checked against the bus on every cycle.
module tb_uart_wb_master;
    localparam int CLK_HZ  = 1600;
    localparam int BAUD    = 100;
    localparam int DIV     = CLK_HZ / BAUD;
    localparam int TIMEOUT = 255;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        int          len;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic        uart_tx;
    logic        cyc, stb, we, ack, busy;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;

    int          tests = 0;
    int          fails = 0;
    int          ack_delay = -1;
    int          hi_cnt = 0;
    logic [31:0] rd_data = 32'h0;
    txn_t        exp_q[$];
    logic [7:0]  rx_q[$];
    logic [31:0] got;

    always #5 clk = ~clk;

    uart_wb_master #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .uart_rx_i(uart_rx),
        .uart_tx_o(uart_tx),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o (we),
        .wbm_sel_o(sel),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i),
        .wbm_ack_i(ack),
        .busy_o   (busy)
    );

    // Slave: acks in the (ack_delay+1)-th cycle of an active cycle; -1 never acks.
    always @(posedge clk) hi_cnt <= cyc ? hi_cnt + 1 : 0;
    assign ack   = cyc && stb && (ack_delay >= 0) && (hi_cnt == ack_delay);
    assign dat_i = rd_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus checker: every cycle while out of reset.
    initial begin
        logic prev_cyc;
        int   len_cnt;
        prev_cyc = 1'b0;
        len_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cyc = 1'b0;
                len_cnt  = 0;
            end else begin
                chk("stb_eq_cyc", 32'(stb), 32'(cyc));
                chk("sel", 32'(sel), cyc ? 32'hF : 32'h0);
                if (cyc) begin
                    chk("pending_txn", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) begin
                        chk("adr", adr, exp_q[0].adr);
                        chk("we", 32'(we), 32'(exp_q[0].we));
                        if (exp_q[0].we) chk("dat_o", dat_o, exp_q[0].dat);
                    end
                    chk("busy_in_bus", 32'(busy), 32'h1);
                    len_cnt++;
                end else if (prev_cyc && exp_q.size() != 0) begin
                    chk("cyc_len", 32'(len_cnt), 32'(exp_q[0].len));
                    $display("[TB] bus txn adr=%08h we=%0d len=%0d", exp_q[0].adr, exp_q[0].we, len_cnt);
                    void'(exp_q.pop_front());
                    len_cnt = 0;
                end
                prev_cyc = cyc;
            end
        end
    end

    // Host receiver: samples mid-bit, queues each byte.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (DIV) @(negedge clk);
                        b[i] = uart_tx;
                    end
                    repeat (DIV) @(negedge clk);
                    chk("tx_stop", 32'(uart_tx), 32'h1);
                    rx_q.push_back(b);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // Sends a command and checks the response derived from the command rules.
    task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rdata, input int delay, output logic [31:0] res);
        txn_t       t;
        logic [7:0] exp_b[4];
        logic [7:0] b;
        int         n, budget;
        bit         valid, ok;
        valid     = (cmd == 8'h57 || cmd == 8'h52);
        ok        = (delay >= 0 && delay < TIMEOUT);
        ack_delay = delay;
        rd_data   = rdata;
        if (valid) begin
            t.adr = a; t.we = (cmd == 8'h57); t.dat = d;
            t.len = ok ? delay + 1 : TIMEOUT;
            exp_q.push_back(t);
        end
        if (valid && ok && cmd == 8'h52) begin
            n = 4;
            for (int i = 0; i < 4; i++) exp_b[i] = rdata[31 - 8 * i -: 8];
        end else begin
            n = 1;
            exp_b[0] = (valid && ok) ? 8'h06 : 8'h15;
        end
        send_byte(cmd, 1'b1);
        chk("busy_after_cmd", 32'(busy), 32'h1);
        if (valid) begin
            for (int i = 0; i < 4; i++) send_byte(a[31 - 8 * i -: 8], 1'b1);
            if (cmd == 8'h57) for (int i = 0; i < 4; i++) send_byte(d[31 - 8 * i -: 8], 1'b1);
        end
        budget = 0;
        while (rx_q.size() < n && budget < 30 * DIV * 4 + 2 * TIMEOUT) begin
            @(negedge clk);
            budget++;
        end
        chk("resp_count", 32'(rx_q.size()), 32'(n));
        res = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (rx_q.size() != 0) begin
                b = rx_q.pop_front();
                chk("resp_byte", 32'(b), 32'(exp_b[i]));
                res = {res[23:0], b};
            end
        end
        repeat (DIV) @(negedge clk);
        chk("busy_idle", 32'(busy), 32'h0);
        chk("bus_done", 32'(exp_q.size()), 32'h0);
        chk("no_extra_bytes", 32'(rx_q.size()), 32'h0);
        chk("tx_idle", 32'(uart_tx), 32'h1);
        $display("[TB] cmd %02h adr=%08h resp=%08h (%0d bytes)", cmd, a, res, n);
    endtask

    initial begin
        int budget;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(uart_tx), 32'h1);
        chk("rst_cyc", 32'(cyc), 32'h0);
        chk("rst_stb", 32'(stb), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_adr", adr, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_cmd(8'h57, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0, 3, got);
        chk("lit_write_ack", got, 32'h0000_0006);
        run_cmd(8'h52, 32'h3000_0000, 32'h0, 32'h1234_5678, 0, got);
        chk("lit_read_data", got, 32'h1234_5678);
        run_cmd(8'h52, 32'h3000_0008, 32'h0, 32'hFFFF_FFFF, -1, got);
        chk("lit_timeout_nak", got, 32'h0000_0015);
        run_cmd(8'h52, 32'h3000_000C, 32'h0, 32'hA5A5_0F0F, 254, got);
        chk("lit_late_ack", got, 32'hA5A5_0F0F);
        run_cmd(8'h41, 32'h0, 32'h0, 32'h0, 0, got);
        chk("lit_bad_cmd", got, 32'h0000_0015);
        run_cmd(8'h57, 32'h1000_0008, 32'hCAFE_F00D, 32'h0, 1, got);

        // Framing error on the second address byte: no bus cycle, no response.
        send_byte(8'h57, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (40 * DIV) @(negedge clk);
        chk("ferr_no_resp", 32'(rx_q.size()), 32'h0);
        chk("ferr_busy", 32'(busy), 32'h0);
        $display("[TB] framing error injected, no response expected");
        run_cmd(8'h57, 32'h2000_0010, 32'h0123_4567, 32'h0, 2, got);

        // Reset while a read cycle is held open by a slave that never acks.
        ack_delay = -1;
        exp_q.push_back('{adr: 32'h5000_0000, we: 1'b0, dat: 32'h0, len: TIMEOUT});
        send_byte(8'h52, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h50 >> (8 * i), 1'b1);
        budget = 0;
        while (!cyc && budget < 20 * DIV) begin
            @(negedge clk);
            budget++;
        end
        chk("cyc_before_reset", 32'(cyc), 32'h1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", 32'(cyc), 32'h0);
        chk("async_rst_stb", 32'(stb), 32'h0);
        chk("async_rst_sel", 32'(sel), 32'h0);
        chk("async_rst_tx", 32'(uart_tx), 32'h1);
        chk("async_rst_busy", 32'(busy), 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20 * DIV) @(negedge clk);
        chk("rst_no_resp", 32'(rx_q.size()), 32'h0);
        $display("[TB] reset during bus cycle, no response expected");
        run_cmd(8'h52, 32'h4000_0000, 32'h0, 32'h89AB_CDEF, 5, got);
        chk("lit_read_after_rst", got, 32'h89AB_CDEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end
endmodule
